// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared defaults, FSM states and frame lengths for the reg_file serial master
package reg_file_pkg;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;
  localparam int WR_FRAME_LEN = DEF_ADDR_W + DEF_DATA_W;
  localparam int RD_ADDR_LEN = DEF_ADDR_W;
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, RWAIT, RDATA, RESP} state_t;
  function automatic int max3(input int a, input int b, input int c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
endpackage

// File: rtl/reg_file_ser_master.sv
// reg_file_ser_master: serialises host read/write requests onto the reg_file 1-bit interface
module reg_file_ser_master
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WR,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [DATA_W-1:0] REQ_WDATA,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [DATA_W-1:0] RSP_RDATA,
  output logic              WR_EN,
  output logic              RD_EN,
  output logic              DIN,
  input  logic              DOUT
);
  localparam int CW = $clog2(max3(ADDR_W, DATA_W, RD_LAT) + 1);
  localparam int TW = ADDR_W + DATA_W;
  state_t state;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tx;
  logic last;
  assign last = cnt == '0;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt <= '0;
      tx <= '0;
      REQ_READY <= 1'b0;
      RSP_VALID <= 1'b0;
      RSP_RDATA <= '0;
      WR_EN <= 1'b0;
      RD_EN <= 1'b0;
      DIN <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (REQ_VALID && REQ_READY) begin
            state <= ADDR;
            REQ_READY <= 1'b0;
            WR_EN <= REQ_WR;
            RD_EN <= !REQ_WR;
            DIN <= REQ_ADDR[ADDR_W-1];
            tx <= {REQ_ADDR, REQ_WDATA} << 1;
            cnt <= CW'(ADDR_W - 1);
          end else REQ_READY <= 1'b1;
        end
        ADDR: begin
          DIN <= tx[TW-1];
          tx <= tx << 1;
          cnt <= cnt - 1'b1;
          if (last && WR_EN) begin
            state <= WDATA;
            cnt <= CW'(DATA_W - 1);
          end else if (last) begin
            RD_EN <= 1'b0;
            DIN <= 1'b0;
            state <= RD_LAT == 1 ? RDATA : RWAIT;
            cnt <= CW'(RD_LAT == 1 ? DATA_W - 1 : RD_LAT - 2);
          end
        end
        WDATA: begin
          DIN <= last ? 1'b0 : tx[TW-1];
          tx <= tx << 1;
          cnt <= cnt - 1'b1;
          if (last) begin
            state <= IDLE;
            WR_EN <= 1'b0;
            REQ_READY <= 1'b1;
          end
        end
        RWAIT: begin
          cnt <= last ? CW'(DATA_W - 1) : cnt - 1'b1;
          if (last) state <= RDATA;
        end
        RDATA: begin
          RSP_RDATA <= {RSP_RDATA[DATA_W-2:0], DOUT};
          cnt <= cnt - 1'b1;
          if (last) begin
            state <= RESP;
            RSP_VALID <= 1'b1;
          end
        end
        RESP: begin
          if (RSP_READY) begin
            state <= IDLE;
            RSP_VALID <= 1'b0;
            REQ_READY <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_file_ser_master.sv
// tb_reg_file_ser_master: directed checks of the serial master at read latencies 1 and 3
module tb_reg_file_ser_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int total = 0;
  int bad = 0;
  logic v1 = 1'b0, w1 = 1'b0, rr1 = 1'b1, do1 = 1'b1;
  logic [3:0] a1 = '0;
  logic [7:0] d1 = '0, mdat1 = '0;
  logic r1, rv1, we1, re1, di1;
  logic [7:0] rd1;
  logic v3 = 1'b0, w3 = 1'b0, rr3 = 1'b1, do3 = 1'b1;
  logic [3:0] a3 = '0;
  logic [7:0] d3 = '0, mdat3 = '0;
  logic r3, rv3, we3, re3, di3;
  logic [7:0] rd3;
  int since1 = 100, since3 = 100;
  int rsp1 = 0, wcyc1 = 0, rcyc1 = 0, both1 = 0;

  reg_file_ser_master #(.ADDR_W(4), .DATA_W(8), .RD_LAT(1)) u1 (
    .CLK(clk), .RST(rst), .REQ_VALID(v1), .REQ_READY(r1), .REQ_WR(w1), .REQ_ADDR(a1),
    .REQ_WDATA(d1), .RSP_VALID(rv1), .RSP_READY(rr1), .RSP_RDATA(rd1), .WR_EN(we1),
    .RD_EN(re1), .DIN(di1), .DOUT(do1));

  reg_file_ser_master #(.ADDR_W(4), .DATA_W(8), .RD_LAT(3)) u3 (
    .CLK(clk), .RST(rst), .REQ_VALID(v3), .REQ_READY(r3), .REQ_WR(w3), .REQ_ADDR(a3),
    .REQ_WDATA(d3), .RSP_VALID(rv3), .RSP_READY(rr3), .RSP_RDATA(rd3), .WR_EN(we3),
    .RD_EN(re3), .DIN(di3), .DOUT(do3));

  // reg_file read-data model: MSB appears RD_LAT cycles after the last RD_EN-high cycle
  always @(posedge clk) begin
    since1 = re1 ? 0 : since1 + 1;
    since3 = re3 ? 0 : since3 + 1;
    do1 <= (since1 < 8) ? mdat1[7-since1] : 1'b1;
    do3 <= (since3 >= 2 && since3 < 10) ? mdat3[9-since3] : 1'b1;
    if (rv1 && rr1) rsp1++;
    if (we1) wcyc1++;
    if (re1) rcyc1++;
    if (we1 && re1) both1++;
  end

  task automatic wait_ready1(input string tag);
    for (int i = 0; i < 40 && r1 !== 1'b1; i++) @(negedge clk);
    total++;
    if (r1 !== 1'b1) begin bad++; $display("FAIL %s_ready got=%b exp=1", tag, r1); end
  endtask

  task automatic test_reset();
    rst = 1'b1; v1 = 1'b1; w1 = 1'b1; v3 = 1'b1; w3 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if ({r1, we1, re1, di1, rv1, rd1} !== 13'b0) begin
        bad++; $display("FAIL reset1_c%0d got=%b exp=0", c, {r1, we1, re1, di1, rv1, rd1});
      end
      total++;
      if ({r3, we3, re3, di3, rv3, rd3} !== 13'b0) begin
        bad++; $display("FAIL reset3_c%0d got=%b exp=0", c, {r3, we3, re3, di3, rv3, rd3});
      end
    end
    rst = 1'b0; v1 = 1'b0; v3 = 1'b0;
    @(negedge clk);
    total++;
    if ({r1, r3} !== 2'b11) begin bad++; $display("FAIL reset_release got=%b exp=11", {r1, r3}); end
  endtask

  task automatic test_write(input logic [3:0] a, input logic [7:0] d);
    logic [11:0] s;
    logic [4:0] got, exp;
    s = {a, d};
    wait_ready1("write");
    v1 = 1'b1; w1 = 1'b1; a1 = a; d1 = d;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      if (c == 1) begin v1 = 1'b0; w1 = 1'b0; a1 = ~a; d1 = ~d; end
      exp = c <= 12 ? {3'b010, s[12-c], 1'b0} : 5'b10000;
      got = {r1, we1, re1, di1, rv1};
      total++;
      if (got !== exp) begin bad++; $display("FAIL write_c%0d got=%b exp=%b", c, got, exp); end
    end
  endtask

  task automatic test_read1(input logic [3:0] a, input logic [7:0] dat);
    logic [4:0] got, exp;
    mdat1 = dat; rr1 = 1'b1;
    wait_ready1("read1");
    v1 = 1'b1; w1 = 1'b0; a1 = a; d1 = 8'hFF;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) begin v1 = 1'b0; a1 = ~a; end
      exp = c <= 4 ? {3'b001, a[4-c], 1'b0} : c <= 12 ? 5'b00000 : c == 13 ? 5'b00001 : 5'b10000;
      got = {r1, we1, re1, di1, rv1};
      total++;
      if (got !== exp) begin bad++; $display("FAIL read1_c%0d got=%b exp=%b", c, got, exp); end
      if (c == 13) begin
        total++;
        if (rd1 !== dat) begin bad++; $display("FAIL read1_data got=%h exp=%h", rd1, dat); end
      end
    end
  endtask

  task automatic test_read_lat3(input logic [3:0] a, input logic [7:0] dat);
    logic [4:0] got, exp;
    mdat3 = dat; rr3 = 1'b0;
    for (int i = 0; i < 40 && r3 !== 1'b1; i++) @(negedge clk);
    total++;
    if (r3 !== 1'b1) begin bad++; $display("FAIL read3_ready got=%b exp=1", r3); end
    v3 = 1'b1; w3 = 1'b0; a3 = a;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      if (c == 1) begin v3 = 1'b0; a3 = ~a; end
      exp = c <= 4 ? {3'b001, a[4-c], 1'b0} : c <= 14 ? 5'b00000 : c <= 20 ? 5'b00001 : 5'b10000;
      got = {r3, we3, re3, di3, rv3};
      total++;
      if (got !== exp) begin bad++; $display("FAIL read3_c%0d got=%b exp=%b", c, got, exp); end
      if (c >= 15 && c <= 20) begin
        total++;
        if (rd3 !== dat) begin bad++; $display("FAIL read3_data_c%0d got=%h exp=%h", c, rd3, dat); end
      end
      if (c == 20) rr3 = 1'b1;
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] got, exp;
    int w0, r0, p0, b0;
    logic [3:0] ra;
    ra = 4'hC; mdat1 = 8'h4E; rr1 = 1'b1;
    wait_ready1("b2b");
    w0 = wcyc1; r0 = rcyc1; p0 = rsp1; b0 = both1;
    v1 = 1'b1; w1 = 1'b1; a1 = 4'h5; d1 = 8'h81;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin w1 = 1'b0; a1 = ra; d1 = 8'h00; end
      if (c == 14) v1 = 1'b0;
      exp = c <= 12 ? 5'b01000 : c == 13 ? 5'b10000 : c <= 17 ? {3'b001, ra[17-c], 1'b0} :
            c <= 25 ? 5'b00000 : c == 26 ? 5'b00001 : 5'b10000;
      got = {r1, we1, re1, (c >= 14 && c <= 17) ? di1 : 1'b0, rv1};
      if (c <= 27) begin
        total++;
        if (got !== exp) begin bad++; $display("FAIL b2b_c%0d got=%b exp=%b", c, got, exp); end
      end
      if (c == 26) begin
        total++;
        if (rd1 !== 8'h4E) begin bad++; $display("FAIL b2b_data got=%h exp=4e", rd1); end
      end
    end
    total++;
    if ({wcyc1 - w0, rcyc1 - r0, rsp1 - p0, both1 - b0} !== {32'd12, 32'd4, 32'd1, 32'd0}) begin
      bad++;
      $display("FAIL b2b_counts got=wr%0d rd%0d rsp%0d both%0d exp=wr12 rd4 rsp1 both0",
               wcyc1 - w0, rcyc1 - r0, rsp1 - p0, both1 - b0);
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] got;
    int p0;
    wait_ready1("rstmid");
    p0 = rsp1;
    v1 = 1'b1; w1 = 1'b1; a1 = 4'h9; d1 = 8'hF0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) v1 = 1'b0;
      got = {r1, we1, re1, di1, rv1};
      total++;
      if (c <= 6 && got[3] !== 1'b1) begin bad++; $display("FAIL rstmid_wr_c%0d got=%b exp=1", c, got[3]); end
      if (c == 7 && got !== 5'b00000) begin bad++; $display("FAIL rstmid_abort got=%b exp=00000", got); end
      if (c == 8 && got !== 5'b10000) begin bad++; $display("FAIL rstmid_release got=%b exp=10000", got); end
      if (c == 6) rst = 1'b1;
      if (c == 7) rst = 1'b0;
    end
    total++;
    if (rsp1 !== p0) begin bad++; $display("FAIL rstmid_rsp got=%0d exp=%0d", rsp1, p0); end
    test_write(4'h6, 8'h3B);
  endtask

  initial begin
    test_reset();
    test_write(4'hA, 8'h5C);
    test_read1(4'h3, 8'hA5);
    test_read_lat3(4'h6, 8'h3C);
    test_back_to_back();
    test_reset_mid();
    total++;
    if (both1 !== 0) begin bad++; $display("FAIL wr_rd_overlap got=%0d exp=0", both1); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule

// File: doc/reg_file_ser_master.md
Name: reg_file_ser_master

Overview:
- Upstream access controller for the serial register file (reg_file, ports WR_EN/RD_EN/DIN/DOUT).
- Accepts parallel read/write requests from a host-side block over a valid/ready handshake.
- Serialises each request onto the register file's 1-bit interface and deserialises read data from DOUT.
- Returns read data over a valid/ready response channel. Exactly one transaction is in flight at a time.

Parameters:
- ADDR_W, 4, register address width in bits.
- DATA_W, 8, register data width in bits.
- RD_LAT, 1, cycles from the last RD_EN-high cycle to the cycle DOUT carries the data MSB. Legal range 1..7.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  controller can accept a request.
- REQ_WR  in  1  1 = write, 0 = read.
- REQ_ADDR  in  ADDR_W  register address.
- REQ_WDATA  in  DATA_W  write data; ignored for reads.
- RSP_VALID  out  1  read data available.
- RSP_READY  in  1  host accepts the response.
- RSP_RDATA  out  DATA_W  read data.
- WR_EN  out  1  to reg_file: write frame active.
- RD_EN  out  1  to reg_file: read address phase active.
- DIN  out  1  to reg_file: serial address/data, MSB first.
- DOUT  in  1  from reg_file: serial read data, MSB first.

Behaviour:
- One clock CLK. Reset is synchronous and active-high on RST.
- Reset values:
  - REQ_READY=0 during reset; 1 in the first cycle after RST deasserts.
  - WR_EN=0, RD_EN=0, DIN=0, RSP_VALID=0, RSP_RDATA=0.
  - FSM goes to IDLE; bit counter and shift registers clear.
- RST asserted mid-frame aborts the frame. Outputs take reset values on the next edge; no partial response is issued.
- All reg_file-side outputs (WR_EN, RD_EN, DIN) are registered.
- Handshake and capture:
  - A request is accepted on an edge where REQ_VALID && REQ_READY.
  - REQ_READY=1 only in IDLE.
  - REQ_WR, REQ_ADDR and REQ_WDATA are captured into a shift register at acceptance. Host may change them afterwards.
- FSM states: IDLE, ADDR, WDATA, RWAIT, RDATA, RESP.
  - IDLE -> ADDR on acceptance.
  - ADDR: WR_EN (write) or RD_EN (read) = 1 for exactly ADDR_W cycles; DIN = address MSB first.
    - Exit to WDATA (write) or RWAIT (read).
  - WDATA: WR_EN stays 1 for DATA_W more cycles (contiguous with ADDR); DIN = data MSB first. Exit to IDLE.
    - Write frame: WR_EN high for ADDR_W+DATA_W consecutive cycles.
    - No response is generated for writes.
  - RWAIT: RD_EN=0, DIN=0 for RD_LAT-1 cycles; zero cycles when RD_LAT=1.
  - RDATA: sample DOUT for DATA_W consecutive cycles.
    - The first sampled cycle is the RD_LAT-th cycle after the last RD_EN-high cycle.
    - Shift in MSB first; RD_EN=0 throughout. Exit to RESP.
  - RESP: RSP_VALID=1 and RSP_RDATA stable until the edge where RSP_READY=1, then go to IDLE.
    - If RSP_READY is already high on the first RESP cycle, RESP lasts exactly one cycle.
- Latency, write (ADDR_W=4, DATA_W=8): accepted at edge 0, WR_EN high cycles 1..12, REQ_READY=1 again cycle 13.
- Latency, read (RD_LAT=1): RD_EN high cycles 1..4, DOUT sampled cycles 5..12, RSP_VALID=1 from cycle 13.
- Bit counter: width clog2(max(ADDR_W,DATA_W,RD_LAT)+1). Reloads at every state entry; no wrap is ever used.
- WR_EN and RD_EN are never high in the same cycle. DIN=0 whenever both are low.
- REQ_VALID while busy is held off (REQ_READY=0). The request is neither dropped nor duplicated.

Decomposition:
- Package reg_file_pkg holds ADDR_W/DATA_W defaults, the FSM state enum (state_t), and the frame-length constants WR_FRAME_LEN = ADDR_W+DATA_W and RD_ADDR_LEN = ADDR_W.
- No sub-module. A single module with FSM, one bit counter, one TX shift register and one RX shift register is sufficient.

Test Plan:
- Reset: hold RST 3 cycles with REQ_VALID=1 -> REQ_READY, WR_EN, RD_EN, DIN, RSP_VALID all 0; REQ_READY=1 the cycle after RST drops.
- Write addr=0xA, data=0x5C -> WR_EN high 12 cycles; DIN sequence 1010_01011100; RD_EN stays 0; REQ_READY returns cycle 13.
- Read addr=0x3, DOUT model returns 0xA5 with RD_LAT=1 -> RD_EN high 4 cycles with DIN 0011; RSP_VALID cycle 13 with RSP_RDATA=0xA5.
- Read with RD_LAT=3, RSP_READY held 0 for 5 cycles -> 2 idle cycles before sampling; RSP_VALID and RSP_RDATA stay stable until RSP_READY=1, then REQ_READY=1 next cycle.
- Back-to-back: REQ_VALID held high with write then read queued -> second request accepted only when REQ_READY=1; frames non-overlapping; exactly one response.
- RST asserted during cycle 6 of a write frame -> WR_EN=0 next edge, no response; a new write afterwards completes correctly.
